// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the fetch stage
//   (I side) and the MEM stage (D side). One transaction is issued at a time;
//   read data is routed back to whichever side owns the outstanding access.
//   A new access may be issued in the same cycle the previous one completes,
//   giving one transaction every MEM_LAT cycles.
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   i_req/i_addr                 fetch request (level, held until i_gnt)
//   i_gnt/i_rvalid/i_rdata       fetch accept pulse, data valid, data
//   d_req/d_we/d_addr/d_wdata/d_be   data-side request and write fields
//   d_gnt/d_rvalid/d_rdata       data accept pulse, read valid / write done, data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be   memory strobe and fields
//   mem_rdata                    memory data, valid MEM_LAT cycles after mem_en
//   busy                         a transaction is outstanding
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic { S_IDLE, S_WAIT } state_t;
    typedef enum logic { OWN_D, OWN_I } owner_t;

    state_t           state, state_nxt;
    owner_t           owner, owner_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic [STV_W-1:0] starve_cnt, starve_cnt_nxt;

    logic last_cycle;
    logic can_issue;
    logic issue;
    logic i_wins;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_D;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        lat_cnt_nxt    = lat_cnt;
        starve_cnt_nxt = starve_cnt;
        i_gnt          = 1'b0;
        d_gnt          = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_be         = '0;

        // The final WAIT cycle doubles as an issue slot so back-to-back
        // accesses run at full memory throughput.
        last_cycle = (state == S_WAIT) && (lat_cnt == LAT_W'(1));
        can_issue  = (state == S_IDLE) || last_cycle;
        issue      = !reset && can_issue && (i_req || d_req);
        i_wins     = i_req && (!d_req || (starve_cnt == STV_W'(STARVE_MAX)));

        i_rvalid = !reset && last_cycle && (owner == OWN_I);
        d_rvalid = !reset && last_cycle && (owner == OWN_D);
        busy     = !reset && (state == S_WAIT);
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;

        if (state == S_WAIT) begin
            lat_cnt_nxt = lat_cnt - LAT_W'(1);
            if (last_cycle)
                state_nxt = S_IDLE;
        end

        if (issue) begin
            mem_en      = 1'b1;
            state_nxt   = S_WAIT;
            lat_cnt_nxt = LAT_W'(MEM_LAT);
            if (i_wins) begin
                i_gnt     = 1'b1;
                owner_nxt = OWN_I;
                mem_addr  = i_addr;
            end else begin
                d_gnt     = 1'b1;
                owner_nxt = OWN_D;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end
        end

        // Starvation counts only contested losses; it saturates and is
        // cleared whenever fetch is idle or gets the port.
        if (!i_req || i_gnt)
            starve_cnt_nxt = '0;
        else if (d_gnt && (starve_cnt != STV_W'(STARVE_MAX)))
            starve_cnt_nxt = starve_cnt + STV_W'(1);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Three arbiter instances (MEM_LAT = 1, 2, 3) each backed by a small
//   byte-enabled model memory with a MEM_LAT-deep read pipeline.
//   Instance 0 runs the vector table and the contention sequence,
//   instance 1 the back-to-back write/read, instance 2 reset-mid-op and busy.
module tb_mem_port_arbiter;

    localparam logic [31:0] IA = 32'h0040_0000;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst      [3];
    logic        i_req    [3];
    logic [31:0] i_addr   [3];
    logic        i_gnt    [3];
    logic        i_rvalid [3];
    logic [31:0] i_rdata  [3];
    logic        d_req    [3];
    logic        d_we     [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic [3:0]  d_be     [3];
    logic        d_gnt    [3];
    logic        d_rvalid [3];
    logic [31:0] d_rdata  [3];
    logic        mem_en   [3];
    logic        mem_we   [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic [3:0]  mem_be   [3];
    logic        busy     [3];

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int unsigned LAT = k + 1;
        logic [31:0] mem_rdata;
        logic [31:0] mem_arr [256];
        logic [31:0] pipe    [LAT];

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)
        ) u_dut (
            .clock(clock), .reset(rst[k]),
            .i_req(i_req[k]), .i_addr(i_addr[k]), .i_gnt(i_gnt[k]),
            .i_rvalid(i_rvalid[k]), .i_rdata(i_rdata[k]),
            .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]),
            .d_wdata(d_wdata[k]), .d_be(d_be[k]), .d_gnt(d_gnt[k]),
            .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
            .mem_wdata(mem_wdata[k]), .mem_be(mem_be[k]),
            .mem_rdata(mem_rdata), .busy(busy[k])
        );

        // Model memory: preloaded while reset is high, word-indexed by addr[9:2].
        always @(posedge clock) begin
            if (rst[k]) begin
                for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
                mem_arr[0] <= 32'h8C08_0000;
            end else if (mem_en[k]) begin
                if (mem_we[k])
                    for (int b = 0; b < 4; b++)
                        if (mem_be[k][b])
                            mem_arr[mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
                pipe[0] <= mem_arr[mem_addr[k][9:2]];
            end
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
        assign mem_rdata = pipe[LAT-1];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int k, input logic r, input logic ir, input logic [31:0] ia,
                          input logic dr, input logic dwe, input logic [31:0] da,
                          input logic [31:0] dwd, input logic [3:0] dbe);
        rst[k]    = r;
        i_req[k]  = ir;
        i_addr[k] = ia;
        d_req[k]  = dr;
        d_we[k]   = dwe;
        d_addr[k] = da;
        d_wdata[k] = dwd;
        d_be[k]   = dbe;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dwe;
        logic [31:0] da, dwd;
        logic [3:0]  dbe;
        logic        ig, dg, en, we;
        logic [31:0] ma, mwd;
        logic [3:0]  mbe;
        logic        irv, drv, bsy, chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [13];

    task automatic check_vec(input int r);
        string p;
        p = $sformatf("vec%0d", r);
        chk({p, ".i_gnt"},     {31'h0, i_gnt[0]},    {31'h0, tbl[r].ig});
        chk({p, ".d_gnt"},     {31'h0, d_gnt[0]},    {31'h0, tbl[r].dg});
        chk({p, ".mem_en"},    {31'h0, mem_en[0]},   {31'h0, tbl[r].en});
        chk({p, ".mem_we"},    {31'h0, mem_we[0]},   {31'h0, tbl[r].we});
        chk({p, ".mem_addr"},  mem_addr[0],          tbl[r].ma);
        chk({p, ".mem_wdata"}, mem_wdata[0],         tbl[r].mwd);
        chk({p, ".mem_be"},    {28'h0, mem_be[0]},   {28'h0, tbl[r].mbe});
        chk({p, ".i_rvalid"},  {31'h0, i_rvalid[0]}, {31'h0, tbl[r].irv});
        chk({p, ".d_rvalid"},  {31'h0, d_rvalid[0]}, {31'h0, tbl[r].drv});
        chk({p, ".busy"},      {31'h0, busy[0]},     {31'h0, tbl[r].bsy});
        if (tbl[r].chk_rd) begin
            if (tbl[r].irv) chk({p, ".i_rdata"}, i_rdata[0], tbl[r].rd);
            else            chk({p, ".d_rdata"}, d_rdata[0], tbl[r].rd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_i;

        //            rst ir ia  dr dwe da            dwd            dbe      ig dg en we ma            mwd           mbe     irv drv bsy chk rd
        tbl[0]  = '{1'b1,1'b1,IA,1'b1,1'b0,32'h20,32'h0,        4'h0,  1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,        4'h0,  1'b0,1'b0,1'b0,1'b0,32'h0};
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = '{1'b0,1'b1,IA,1'b1,1'b0,32'h20,32'h0,        4'h0,  1'b0,1'b1,1'b1,1'b0,32'h20,32'h0,        4'h0,  1'b0,1'b0,1'b0,1'b0,32'h0};
        tbl[4]  = '{1'b0,1'b1,IA,1'b0,1'b1,32'h44,32'hFFFF_FFFF,4'hF,  1'b1,1'b0,1'b1,1'b0,IA,    32'h0,        4'h0,  1'b0,1'b1,1'b1,1'b0,32'h0};
        tbl[5]  = '{1'b0,1'b0,IA,1'b0,1'b1,32'h44,32'hFFFF_FFFF,4'hF,  1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,        4'h0,  1'b1,1'b0,1'b1,1'b1,32'h8C08_0000};
        tbl[6]  = '{1'b0,1'b0,IA,1'b0,1'b1,32'h44,32'hFFFF_FFFF,4'hF,  1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,        4'h0,  1'b0,1'b0,1'b0,1'b0,32'h0};
        tbl[7]  = '{1'b0,1'b0,IA,1'b1,1'b1,32'h14,32'h1234_5678,4'h3,  1'b0,1'b1,1'b1,1'b1,32'h14,32'h1234_5678,4'h3,  1'b0,1'b0,1'b0,1'b0,32'h0};
        tbl[8]  = tbl[6]; tbl[8].drv = 1'b1; tbl[8].bsy = 1'b1;
        tbl[9]  = tbl[6];
        tbl[10] = '{1'b0,1'b1,IA,1'b0,1'b1,32'h44,32'hFFFF_FFFF,4'hF,  1'b1,1'b0,1'b1,1'b0,IA,    32'h0,        4'h0,  1'b0,1'b0,1'b0,1'b0,32'h0};
        tbl[11] = tbl[5];
        tbl[12] = tbl[6];

        for (int k = 0; k < 3; k++) set_in(k, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) cyc();

        // Vector table on the MEM_LAT=1 instance.
        for (int r = 0; r < 13; r++) begin
            cyc();
            set_in(0, tbl[r].rst, tbl[r].ir, tbl[r].ia, tbl[r].dr, tbl[r].dwe,
                   tbl[r].da, tbl[r].dwd, tbl[r].dbe);
            #2;
            check_vec(r);
        end

        // Contention with both requests held: D D D D I D D D D I.
        cyc();
        set_in(0, 1'b1, 1'b1, IA, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        exp_i = 10'b10_0001_0000;
        for (int c = 0; c < 10; c++) begin
            cyc();
            set_in(0, 1'b0, 1'b1, IA, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
            #2;
            chk($sformatf("cont%0d.i_gnt", c), {31'h0, i_gnt[0]}, {31'h0, exp_i[c]});
            chk($sformatf("cont%0d.d_gnt", c), {31'h0, d_gnt[0]}, {31'h0, !exp_i[c]});
            chk($sformatf("cont%0d.both_gnt", c), {31'h0, i_gnt[0] && d_gnt[0]}, 32'h0);
        end
        cyc();
        set_in(0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Back-to-back write then read, MEM_LAT=2.
        cyc();
        set_in(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #2;
        chk("b2b.c0.d_gnt",    {31'h0, d_gnt[1]},  32'h1);
        chk("b2b.c0.mem_en",   {31'h0, mem_en[1]}, 32'h1);
        chk("b2b.c0.mem_we",   {31'h0, mem_we[1]}, 32'h1);
        chk("b2b.c0.mem_addr", mem_addr[1],        32'h10);
        cyc();
        set_in(1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #2;
        chk("b2b.c1.mem_en",   {31'h0, mem_en[1]},   32'h0);
        chk("b2b.c1.d_rvalid", {31'h0, d_rvalid[1]}, 32'h0);
        cyc();
        #2;
        chk("b2b.c2.d_rvalid", {31'h0, d_rvalid[1]}, 32'h1);
        chk("b2b.c2.d_gnt",    {31'h0, d_gnt[1]},    32'h1);
        chk("b2b.c2.mem_en",   {31'h0, mem_en[1]},   32'h1);
        chk("b2b.c2.mem_we",   {31'h0, mem_we[1]},   32'h0);
        cyc();
        set_in(1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        chk("b2b.c3.mem_en",   {31'h0, mem_en[1]},   32'h0);
        chk("b2b.c3.d_rvalid", {31'h0, d_rvalid[1]}, 32'h0);
        chk("b2b.c3.busy",     {31'h0, busy[1]},     32'h1);
        cyc();
        #2;
        chk("b2b.c4.d_rvalid", {31'h0, d_rvalid[1]}, 32'h1);
        chk("b2b.c4.d_rdata",  d_rdata[1],           32'hDEAD_BEEF);

        // Reset in the middle of a MEM_LAT=3 read.
        cyc();
        set_in(2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #2;
        chk("rmid.c0.d_gnt", {31'h0, d_gnt[2]}, 32'h1);
        cyc();
        set_in(2, 1'b1, 1'b1, IA, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #2;
        chk("rmid.c1.busy",   {31'h0, busy[2]},   32'h0);
        chk("rmid.c1.mem_en", {31'h0, mem_en[2]}, 32'h0);
        chk("rmid.c1.d_gnt",  {31'h0, d_gnt[2]},  32'h0);
        cyc();
        set_in(2, 1'b0, 1'b1, IA, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        chk("rmid.c2.busy",     {31'h0, busy[2]},     32'h0);
        chk("rmid.c2.i_gnt",    {31'h0, i_gnt[2]},    32'h1);
        chk("rmid.c2.mem_addr", mem_addr[2],          IA);
        chk("rmid.c2.d_rvalid", {31'h0, d_rvalid[2]}, 32'h0);
        for (int c = 3; c < 6; c++) begin
            cyc();
            set_in(2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #2;
            chk($sformatf("rmid.c%0d.d_rvalid", c), {31'h0, d_rvalid[2]}, 32'h0);
            chk($sformatf("rmid.c%0d.i_rvalid", c), {31'h0, i_rvalid[2]}, {31'h0, c == 5});
        end

        // Busy window for a lone request, MEM_LAT=3.
        cyc();
        set_in(2, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        set_in(2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        #2;
        chk("busy.c0.busy",   {31'h0, busy[2]},   32'h0);
        chk("busy.c0.mem_en", {31'h0, mem_en[2]}, 32'h1);
        for (int c = 1; c < 5; c++) begin
            cyc();
            set_in(2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #2;
            chk($sformatf("busy.c%0d.busy", c),     {31'h0, busy[2]},     {31'h0, c <= 3});
            chk($sformatf("busy.c%0d.mem_en", c),   {31'h0, mem_en[2]},   32'h0);
            chk($sformatf("busy.c%0d.d_rvalid", c), {31'h0, d_rvalid[2]}, {31'h0, c == 3});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
